vec_wb_buffer: RTL and testbench
================================

Name: vec_wb_buffer

Overview:
Downstream neighbour of the 4x32-bit SIMD ALU. It captures each 128-bit ALU result, with its destination vector register and zero flag, into a small in-order queue, and drains that queue to the vector register-file write port under a valid/ready handshake. It also provides operand forwarding of pending results to the operand-fetch stage, so dependent instructions need not wait for writeback.

Parameters:
DATA_W, 128, result width (4 lanes x 32 bits)
DEPTH, 4, queue entries; power of two, minimum 2
REG_AW, 5, destination/source register index width

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous reset, active-low
in_valid  input  1  ALU result beat valid
in_ready  output  1  buffer can accept a beat
in_rd  input  REG_AW  destination register of the beat
in_data  input  DATA_W  ALU result
in_zero  input  1  ALU zero flag (lane 0 == 0)
wb_valid  output  1  head entry valid for writeback
wb_ready  input  1  register file accepts the write
wb_rd  output  REG_AW  head destination register
wb_data  output  DATA_W  head result
wb_zero  output  1  head zero flag
fwd_rs  input  REG_AW  source register being read upstream
fwd_hit  output  1  a pending entry targets fwd_rs
fwd_data  output  DATA_W  data of the youngest matching entry
count  output  clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset: the single clock is clk; reset is rst_n, synchronous, active-low. While rst_n=0 at a rising edge: pointers and count cleared, all entry valid bits cleared. After reset: wb_valid=0, in_ready=1, count=0, fwd_hit=0. wb_rd, wb_data, wb_zero and fwd_data all read 0 when not valid.
- Reset mid-operation: all pending entries are discarded without being written back. No partial state survives.
- Enqueue: occurs when in_valid && in_ready.
- in_ready = (count < DEPTH). It is registered-state only, with no combinational path from wb_ready. A full buffer therefore refuses a beat even in a cycle where it also dequeues.
- in_rd == 0: the beat is accepted (handshake completes) but dropped. It is not stored, count does not change, and it never forwards. x0 is never written.
- Dequeue: occurs when wb_valid && wb_ready. wb_valid = (count != 0). wb_* present the head entry directly from storage.
- Latency: an enqueued beat appears on wb_* in the cycle after acceptance, giving 1-cycle latency.
- Order: strictly FIFO. No reordering and no merging of same-rd entries.
- Simultaneous enqueue and dequeue (count between 1 and DEPTH-1): both happen and count is unchanged.
- Pointer wrap: read and write pointers wrap modulo DEPTH. Full and empty are derived from count, never from pointer equality alone.
- wb_valid holds and wb_* are stable until the dequeue handshake completes.
- Forwarding is combinational over stored valid entries only. An in-flight input beat in the same cycle is not visible.
  - fwd_hit = 1 when any valid entry has rd == fwd_rs and fwd_rs != 0.
  - On multiple matches, the youngest (most recently enqueued) entry wins.
  - fwd_data = 0 when fwd_hit = 0.
  - An entry being dequeued in the current cycle still forwards in that cycle.

Optional Feature:
VWB_BYPASS_EN. Defined: when count==0 and in_valid with in_rd!=0, the input is presented combinationally on wb_* with wb_valid=1.
- If wb_ready=1 in that cycle, the beat completes writeback and is not stored. Latency is 0.
- If wb_ready=0, the beat is stored normally.
- in_ready is unchanged by the feature.

Undefined: no in-to-wb combinational path exists, and latency is always 1.

Decomposition:
- Shared package vec_pkg holds VLEN=128, LANES=4, LANE_W=32, REG_AW=5, the ALU op encodings, and a packed struct wb_entry_t {rd, data, zero}.
- One natural sub-module, vec_fwd_match: a youngest-first parallel compare of fwd_rs against the entry rd/valid vectors and the write-pointer age. It returns the hit and the selected index.
- The queue storage stays inline.

Test Plan:
- Reset then idle: after rst_n low for 2 cycles -> wb_valid=0, in_ready=1, count=0, fwd_hit=0.
- Fill to full:
  - Stimulus: 4 beats, rd=1..4, data=128'h1..4, wb_ready=0.
  - Required: count=4, in_ready=0, and a 5th beat is not accepted.
  - Then wb_ready=1: wb_rd is 1,2,3,4 on consecutive cycles, and count returns to 0.
- Forwarding:
  - Stimulus: enqueue rd=7 data=A, then rd=7 data=B, with wb_ready=0; fwd_rs=7.
  - Required: fwd_hit=1 and fwd_data=B. With fwd_rs=0 -> fwd_hit=0. With fwd_rs=9 -> fwd_hit=0 and fwd_data=0.
- x0 drop: a beat with rd=0, data=128'hFFFF -> accepted, count stays 0, wb_valid stays 0.
- Streaming: continuous in_valid with wb_ready=1, rd cycling 1..31 -> count stays 1 and every beat is written back once, in order, with 1-cycle latency.
  - Under VWB_BYPASS_EN the same stimulus gives count=0 and 0-cycle latency.
- Reset mid-flight: 3 entries queued, rst_n=0 for one edge -> count=0, wb_valid=0, and no further writes occur.

Source files
------------

// File: rtl/vec_pkg.sv
// rtl/vec_pkg.sv - shared vector datapath types and widths
package vec_pkg;

  localparam int VLEN   = 128;
  localparam int LANES  = 4;
  localparam int LANE_W = 32;
  localparam int REG_AW = 5;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_MIN = 4'd7,
    ALU_MAX = 4'd8
  } alu_op_t;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [VLEN-1:0]   data;
    logic              zero;
  } wb_entry_t;

endpackage

// File: rtl/vec_wb_buffer_if.sv
// rtl/vec_wb_buffer_if.sv - ALU result, writeback and forwarding signal bundle
interface vec_wb_buffer_if #(
  parameter int DATA_W = vec_pkg::VLEN,
  parameter int REG_AW = vec_pkg::REG_AW,
  parameter int CNT_W  = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [REG_AW-1:0] in_rd;
  logic [DATA_W-1:0] in_data;
  logic              in_zero;
  logic              wb_valid;
  logic              wb_ready;
  logic [REG_AW-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              wb_zero;
  logic [REG_AW-1:0] fwd_rs;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [CNT_W-1:0]  count;

  modport slave (
    input  in_valid, in_rd, in_data, in_zero, wb_ready, fwd_rs,
    output in_ready, wb_valid, wb_rd, wb_data, wb_zero, fwd_hit, fwd_data, count
  );

  modport master (
    output in_valid, in_rd, in_data, in_zero, wb_ready, fwd_rs,
    input  in_ready, wb_valid, wb_rd, wb_data, wb_zero, fwd_hit, fwd_data, count
  );
endinterface

// File: rtl/vec_fwd_match.sv
// rtl/vec_fwd_match.sv - youngest-first match of a source register against queued entries
module vec_fwd_match
  import vec_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = REG_AW
) (
  input  logic [DEPTH-1:0][AW-1:0]     rd,
  input  logic [DEPTH-1:0]             vld,
  input  logic [$clog2(DEPTH)-1:0]     wptr,
  input  logic [AW-1:0]                rs,
  output logic                         hit,
  output logic [$clog2(DEPTH)-1:0]     idx
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] cand;

  // Scan oldest (slot at wptr) to youngest (wptr-1); the last match overwrites, so youngest wins.
  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    cand = '0;
    if (rs != '0) begin
      for (int k = DEPTH; k >= 1; k--) begin
        cand = wptr - PW'(k);
        if (vld[cand] && (rd[cand] == rs)) begin
          hit = 1'b1;
          idx = cand;
        end
      end
    end
  end
endmodule

// File: rtl/vec_wb_buffer.sv
// rtl/vec_wb_buffer.sv - in-order ALU writeback queue with forwarding; VWB_BYPASS_EN adds empty-queue bypass
module vec_wb_buffer #(
  parameter int DATA_W = vec_pkg::VLEN,
  parameter int DEPTH  = 4,
  parameter int REG_AW = vec_pkg::REG_AW
) (
  input  logic            clk,
  input  logic            rst_n,
  vec_wb_buffer_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DEPTH-1:0][REG_AW-1:0] rd_q;
  logic [DATA_W-1:0]            data_q [DEPTH];
  logic [DEPTH-1:0]             zero_q;
  logic [DEPTH-1:0]             vld_q;
  logic [PW-1:0]                wptr;
  logic [PW-1:0]                rptr;
  logic [CW-1:0]                cnt;
  logic                         byp;
  logic                         acc;
  logic                         enq;
  logic                         deq;
  logic                         hit;
  logic [PW-1:0]                hit_idx;

  assign bus.in_ready = (cnt != FULL);
  assign bus.count    = cnt;
  assign acc          = bus.in_valid && bus.in_ready;

`ifdef VWB_BYPASS_EN
  assign byp = (cnt == '0) && bus.in_valid && (bus.in_rd != '0);
`else
  assign byp = 1'b0;
`endif

  assign deq = (cnt != '0) && bus.wb_ready;
  // x0 beats complete the handshake but are never stored; bypassed beats retire without storage.
  assign enq = acc && (bus.in_rd != '0) && !(byp && bus.wb_ready);

  always_comb begin
    bus.wb_valid = 1'b0;
    bus.wb_rd    = '0;
    bus.wb_data  = '0;
    bus.wb_zero  = 1'b0;
    if (byp) begin
      bus.wb_valid = 1'b1;
      bus.wb_rd    = bus.in_rd;
      bus.wb_data  = bus.in_data;
      bus.wb_zero  = bus.in_zero;
    end else if (cnt != '0) begin
      bus.wb_valid = 1'b1;
      bus.wb_rd    = rd_q[rptr];
      bus.wb_data  = data_q[rptr];
      bus.wb_zero  = zero_q[rptr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      vld_q <= '0;
    end else begin
      if (enq) begin
        vld_q[wptr] <= 1'b1;
        wptr        <= wptr + 1'b1;
      end
      if (deq) begin
        vld_q[rptr] <= 1'b0;
        rptr        <= rptr + 1'b1;
      end
      case ({enq, deq})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Payload needs no reset: every read is qualified by count or a valid bit.
  always_ff @(posedge clk) begin
    if (enq) begin
      rd_q[wptr]   <= bus.in_rd;
      data_q[wptr] <= bus.in_data;
      zero_q[wptr] <= bus.in_zero;
    end
  end

  vec_fwd_match #(
    .DEPTH (DEPTH),
    .AW    (REG_AW)
  ) u_fwd_match (
    .rd   (rd_q),
    .vld  (vld_q),
    .wptr (wptr),
    .rs   (bus.fwd_rs),
    .hit  (hit),
    .idx  (hit_idx)
  );

  assign bus.fwd_hit  = hit;
  assign bus.fwd_data = hit ? data_q[hit_idx] : '0;
endmodule

// File: tb/tb_vec_wb_buffer.sv
// tb/tb_vec_wb_buffer.sv - self-checking bench for vec_wb_buffer
module tb_vec_wb_buffer;
  import vec_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  vec_wb_buffer_if bus ();

  vec_wb_buffer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    logic [4:0]   rd;
    logic [127:0] d;
    logic         wr;
    logic [4:0]   rs;
    logic [2:0]   cnt;
    logic         ir;
    logic         wv;
    logic [4:0]   wrd;
    logic [127:0] wd;
    logic         hit;
    logic [127:0] fd;
  } vec_t;

  localparam logic [127:0] DA = {4{32'hAAAA_0001}};
  localparam logic [127:0] DB = {4{32'hBBBB_0002}};

  vec_t      tbl [20];
  wb_entry_t q [$];
  int        wb_log [$];

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [4:0] rd, input logic [127:0] d,
                              input logic wr, input logic [4:0] rs, input logic [2:0] cnt,
                              input logic ir, input logic wv, input logic [4:0] wrd,
                              input logic [127:0] wd, input logic hit, input logic [127:0] fd);
    vec_t r;
    r.v = v; r.rd = rd; r.d = d; r.wr = wr; r.rs = rs; r.cnt = cnt;
    r.ir = ir; r.wv = wv; r.wrd = wrd; r.wd = wd; r.hit = hit; r.fd = fd;
    return r;
  endfunction

  task automatic drive(input logic v, input logic [4:0] rd, input logic [127:0] d,
                       input logic z, input logic wr, input logic [4:0] rs);
    bus.in_valid = v;
    bus.in_rd    = rd;
    bus.in_data  = d;
    bus.in_zero  = z;
    bus.wb_ready = wr;
    bus.fwd_rs   = rs;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference: queue of pending entries, outputs derived from its contents and the current inputs.
  task automatic model_cycle(input string tag);
    wb_entry_t hd;
    logic      ev;
    logic      hit;
    logic [127:0] fd;
    int        sz;
    logic      deq;
    sz  = q.size();
    ev  = 1'b0;
    hd  = '0;
    hit = 1'b0;
    fd  = '0;
    if (sz > 0) begin
      ev = 1'b1;
      hd = q[0];
    end
`ifdef VWB_BYPASS_EN
    else if (bus.in_valid && bus.in_rd != 0) begin
      ev = 1'b1;
      hd.rd = bus.in_rd; hd.data = bus.in_data; hd.zero = bus.in_zero;
    end
`endif
    if (bus.fwd_rs != 0)
      foreach (q[i]) if (q[i].rd == bus.fwd_rs) begin hit = 1'b1; fd = q[i].data; end
    chk({tag, "_count"},    128'(bus.count),    128'(sz));
    chk({tag, "_in_ready"}, 128'(bus.in_ready), 128'(sz < 4));
    chk({tag, "_wb_valid"}, 128'(bus.wb_valid), 128'(ev));
    chk({tag, "_wb_rd"},    128'(bus.wb_rd),    128'(hd.rd));
    chk({tag, "_wb_data"},  bus.wb_data,        hd.data);
    chk({tag, "_wb_zero"},  128'(bus.wb_zero),  128'(hd.zero));
    chk({tag, "_fwd_hit"},  128'(bus.fwd_hit),  128'(hit));
    chk({tag, "_fwd_data"}, bus.fwd_data,       fd);
    deq = ev && bus.wb_ready;
    if (sz > 0 && deq) void'(q.pop_front());
    if (bus.in_valid && sz < 4 && bus.in_rd != 0 && !(sz == 0 && deq)) begin
      hd.rd = bus.in_rd; hd.data = bus.in_data; hd.zero = bus.in_zero;
      q.push_back(hd);
    end
  endtask

  initial begin
    int bad;
    int wcount;
    logic [127:0] rd_exp;

    tbl[0]  = mk(1, 1, 128'h1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 2, 128'h2, 0, 0, 1, 1, 1, 1, 128'h1, 0, 0);
    tbl[2]  = mk(1, 3, 128'h3, 0, 0, 2, 1, 1, 1, 128'h1, 0, 0);
    tbl[3]  = mk(1, 4, 128'h4, 0, 0, 3, 1, 1, 1, 128'h1, 0, 0);
    tbl[4]  = mk(1, 5, 128'h5, 0, 3, 4, 0, 1, 1, 128'h1, 1, 128'h3);
    tbl[5]  = mk(0, 0, 128'h0, 1, 5, 4, 0, 1, 1, 128'h1, 0, 0);
    tbl[6]  = mk(0, 0, 128'h0, 1, 0, 3, 1, 1, 2, 128'h2, 0, 0);
    tbl[7]  = mk(0, 0, 128'h0, 1, 0, 2, 1, 1, 3, 128'h3, 0, 0);
    tbl[8]  = mk(0, 0, 128'h0, 1, 4, 1, 1, 1, 4, 128'h4, 1, 128'h4);
    tbl[9]  = mk(0, 0, 128'h0, 1, 4, 0, 1, 0, 0, 0, 0, 0);
    tbl[10] = mk(1, 7, DA, 0, 7, 0, 1, 0, 0, 0, 0, 0);
    tbl[11] = mk(1, 7, DB, 0, 7, 1, 1, 1, 7, DA, 1, DA);
    tbl[12] = mk(0, 0, 128'h0, 0, 7, 2, 1, 1, 7, DA, 1, DB);
    tbl[13] = mk(0, 0, 128'h0, 0, 0, 2, 1, 1, 7, DA, 0, 0);
    tbl[14] = mk(0, 0, 128'h0, 0, 9, 2, 1, 1, 7, DA, 0, 0);
    tbl[15] = mk(0, 0, 128'h0, 1, 7, 2, 1, 1, 7, DA, 1, DB);
    tbl[16] = mk(0, 0, 128'h0, 1, 7, 1, 1, 1, 7, DB, 1, DB);
    tbl[17] = mk(0, 0, 128'h0, 0, 7, 0, 1, 0, 0, 0, 0, 0);
    tbl[18] = mk(1, 0, 128'hFFFF, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[19] = mk(0, 0, 128'h0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

`ifdef VWB_BYPASS_EN
    foreach (tbl[i]) if (tbl[i].cnt == 0 && tbl[i].v && tbl[i].rd != 0) begin
      tbl[i].wv  = 1'b1;
      tbl[i].wrd = tbl[i].rd;
      tbl[i].wd  = tbl[i].d;
    end
`endif

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_wb_valid", 128'(bus.wb_valid), 128'(0));
    chk("reset_in_ready", 128'(bus.in_ready), 128'(1));
    chk("reset_count",    128'(bus.count),    128'(0));
    chk("reset_fwd_hit",  128'(bus.fwd_hit),  128'(0));
    chk("reset_wb_data",  bus.wb_data,        128'(0));
    next_cycle();

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].v, tbl[i].rd, tbl[i].d, 1'b0, tbl[i].wr, tbl[i].rs);
      @(negedge clk);
      chk($sformatf("vec%0d_count", i),    128'(bus.count),    128'(tbl[i].cnt));
      chk($sformatf("vec%0d_in_ready", i), 128'(bus.in_ready), 128'(tbl[i].ir));
      chk($sformatf("vec%0d_wb_valid", i), 128'(bus.wb_valid), 128'(tbl[i].wv));
      chk($sformatf("vec%0d_wb_rd", i),    128'(bus.wb_rd),    128'(tbl[i].wrd));
      chk($sformatf("vec%0d_wb_data", i),  bus.wb_data,        tbl[i].wd);
      chk($sformatf("vec%0d_fwd_hit", i),  128'(bus.fwd_hit),  128'(tbl[i].hit));
      chk($sformatf("vec%0d_fwd_data", i), bus.fwd_data,       tbl[i].fd);
      next_cycle();
    end

    // Streaming: rd 1..31 back to back, register file always ready.
    for (int i = 0; i <= 31; i++) begin
      if (i < 31) drive(1, 5'(i + 1), 128'(i + 1), 0, 1, 0);
      else        drive(0, 0, 0, 0, 1, 0);
      @(negedge clk);
`ifdef VWB_BYPASS_EN
      chk($sformatf("stream%0d_count", i), 128'(bus.count), 128'(0));
      rd_exp = (i < 31) ? 128'(i + 1) : 128'(0);
`else
      chk($sformatf("stream%0d_count", i), 128'(bus.count), (i == 0) ? 128'(0) : 128'(1));
      rd_exp = 128'(i);
`endif
      chk($sformatf("stream%0d_wb_rd", i), 128'(bus.wb_rd), rd_exp);
      if (bus.wb_valid && bus.wb_ready) wb_log.push_back(int'(bus.wb_rd));
      next_cycle();
    end
    bad = 0;
    foreach (wb_log[i]) if (wb_log[i] != i + 1) bad++;
    chk("stream_len",   128'(wb_log.size()), 128'(31));
    chk("stream_order", 128'(bad),           128'(0));

    // Reset with three entries pending.
    for (int i = 1; i <= 3; i++) begin
      drive(1, 5'(i), 128'(i), 0, 0, 0);
      next_cycle();
    end
    drive(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("preflush_count", 128'(bus.count), 128'(3));
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("flush_count",    128'(bus.count),    128'(0));
    chk("flush_wb_valid", 128'(bus.wb_valid), 128'(0));
    chk("flush_fwd_hit",  128'(bus.fwd_hit),  128'(0));
    wcount = 0;
    bus.wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      @(negedge clk);
      if (bus.wb_valid) wcount++;
    end
    chk("flush_no_writes", 128'(wcount), 128'(0));
    next_cycle();

    q.delete();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 99) < 40), 5'($urandom_range(0, 7)));
      @(negedge clk);
      model_cycle("rnd");
      next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
